piradspi_shift_engine: RTL
==========================

PIRADSPI_SHIFT_ENGINE -- requirements
Module: piradspi_shift_engine

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, giving the maximum frame length and the tx/rx word width.
REQ-002 SHALL have parameter DIV_WIDTH, default 8, giving the width of the SCLK divider field.
REQ-003 SHALL have port ACLK, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port ARESETN, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port cfg_cpol, input, 1 bit: SCLK idle level.
REQ-006 SHALL have port cfg_cpha, input, 1 bit: 0 = sample on leading edge; 1 = sample on trailing edge.
REQ-007 SHALL have port cfg_div, input, DIV_WIDTH bits: SCLK half-period H = cfg_div+1 ACLK cycles.
REQ-008 SHALL have port cfg_len, input, clog2(DATA_WIDTH) bits: frame bits minus 1.
REQ-009 SHALL have port tx_data, input, DATA_WIDTH bits: word to send, right-justified.
REQ-010 SHALL have port tx_valid, input, 1 bit, and port tx_ready, output, 1 bit: frame-start handshake.
REQ-011 SHALL have port rx_data, output, DATA_WIDTH bits: received word, right-justified, upper bits zero.
REQ-012 SHALL have port rx_valid, output, 1 bit: one-cycle pulse marking rx_data valid.
REQ-013 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-014 SHALL have ports spi_sclk, spi_mosi and spi_cs_n, outputs, 1 bit each, and port spi_miso, input, 1 bit.

Function
REQ-015 SHALL implement states IDLE, SETUP, SHIFT and HOLD.
REQ-016 SHALL drive tx_ready=1 only in IDLE; a handshake (tx_valid & tx_ready) SHALL latch tx_data, cfg_cpol, cfg_cpha, cfg_div and cfg_len, then move to SETUP.
REQ-017 SHALL ignore cfg_* changes during a frame; the latched copy governs the whole frame.
REQ-018 SHALL, in IDLE, hold spi_cs_n=1, spi_sclk=cfg_cpol (registered), and spi_mosi equal to its last value.
REQ-019 SHALL, in SETUP, drive spi_cs_n=0 and the MSB (bit cfg_len) on spi_mosi for H cycles, with spi_sclk at CPOL.
REQ-020 SHALL, in SHIFT, toggle spi_sclk every H cycles for 2*(cfg_len+1) edges, MSB first.
REQ-021 With CPHA=0, SHALL sample spi_miso on odd edges and update spi_mosi on even edges, except the final edge.
REQ-022 With CPHA=1, SHALL update spi_mosi on odd edges and sample spi_miso on even edges.
REQ-023 SHALL, in HOLD, keep spi_cs_n=0 and spi_sclk=CPOL for H cycles, then deassert spi_cs_n, pulse rx_valid for one cycle and return to IDLE.
REQ-024 Handshake-to-rx_valid latency SHALL be exactly (2*(cfg_len+1)+2)*(cfg_div+1) ACLK cycles.
REQ-025 spi_cs_n SHALL stay high for at least one ACLK cycle between back-to-back frames; tx_ready reasserts in the rx_valid cycle.
REQ-026 The divider counter SHALL wrap from cfg_div to 0; cfg_div=0 SHALL give H=1.
REQ-027 The bit counter SHALL reach 0 without underflow; cfg_len=0 SHALL send a 1-bit frame.

Reset
REQ-028 ARESETN low SHALL, at the next ACLK edge, force IDLE in any state (including mid-frame), with spi_cs_n=1, spi_sclk=0, spi_mosi=0, tx_ready=0 during reset, rx_valid=0, rx_data=0 and busy=0.
REQ-029 An aborted frame SHALL NOT produce rx_valid.

Configuration
REQ-030 When macro PIRADSPI_LOOPBACK_EN is defined, SHALL add input cfg_loopback; when cfg_loopback=1, the sampled bit SHALL be the internal spi_mosi register, not spi_miso.
REQ-031 When PIRADSPI_LOOPBACK_EN is undefined, SHALL have no such port and SHALL always sample spi_miso.

Structure
REQ-032 The state enum, DATA_WIDTH/DIV_WIDTH defaults and LEN_WIDTH function SHALL reside in package piradspi_pkg.
REQ-033 The half-period timer SHALL be sub-module piradspi_clk_div, which emits a tick every H cycles, restarting on frame start.

Verification
REQ-034 Test: CPOL=0, CPHA=0, div=0, len=7, tx=0xA5, MISO tied to 0x3C shifter -> MOSI sees 1,0,1,0,0,1,0,1 on rising edges; rx_data=0x0000003C; rx_valid at cycle 18.
REQ-035 Test: CPOL=1, CPHA=1, div=3, len=31, tx=0xDEADBEEF with loopback -> rx_data=0xDEADBEEF; latency 264 cycles; SCLK idles high.
REQ-036 Test: two back-to-back frames with tx_valid held high -> spi_cs_n high for exactly 1 cycle between frames; two rx_valid pulses.
REQ-037 Test: ARESETN low at edge 5 of a len=15 frame -> next cycle spi_cs_n=1, busy=0, no rx_valid; the next frame completes normally.
REQ-038 Test: len=0, div=0, tx=0x1, MISO=1 -> one SCLK pulse; rx_data=0x1; latency 4.
REQ-039 Test: change cfg_div from 0 to 5 mid-frame -> SCLK period stays 2 cycles until frame end.

Source files
------------

// File: rtl/piradspi_pkg.sv
// Shared types and sizing helpers for the PIRADSPI shift engine.
package piradspi_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_DIV_WIDTH  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_e;

  // Width of the frame-length field (frame bits minus one) for a given word width.
  function automatic int unsigned LEN_WIDTH(input int unsigned data_width);
    return (data_width > 1) ? $clog2(data_width) : 1;
  endfunction

endpackage

// File: rtl/piradspi_clk_div.sv
// SCLK half-period timer: tick_c fires on the last cycle of every H = div+1 cycle window.
module piradspi_clk_div #(
  parameter int unsigned DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 restart,
  input  logic                 en,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 tick_c
);

  logic [DIV_WIDTH-1:0] cnt_q;

  assign tick_c = en && !restart && (cnt_q == div);

  // Free-running divider while enabled, wrapping from div back to zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (restart || !en) begin
      cnt_q <= '0;
    end else if (cnt_q == div) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + DIV_WIDTH'(1);
    end
  end

endmodule

// File: rtl/piradspi_shift_engine.sv
// SPI master shift engine: one frame per tx handshake, MSB first, CPOL/CPHA selectable.
// Optional feature macro: PIRADSPI_LOOPBACK_EN adds cfg_loopback (sample MOSI instead of MISO).
module piradspi_shift_engine
  import piradspi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned DIV_WIDTH  = DEF_DIV_WIDTH
) (
  input  logic                              ACLK,
  input  logic                              ARESETN,
  input  logic                              cfg_cpol,
  input  logic                              cfg_cpha,
  input  logic [DIV_WIDTH-1:0]              cfg_div,
  input  logic [LEN_WIDTH(DATA_WIDTH)-1:0]  cfg_len,
`ifdef PIRADSPI_LOOPBACK_EN
  input  logic                              cfg_loopback,
`endif
  input  logic [DATA_WIDTH-1:0]             tx_data,
  input  logic                              tx_valid,
  output logic                              tx_ready,
  output logic [DATA_WIDTH-1:0]             rx_data,
  output logic                              rx_valid,
  output logic                              busy,
  output logic                              spi_sclk,
  output logic                              spi_mosi,
  output logic                              spi_cs_n,
  input  logic                              spi_miso
);

  localparam int unsigned LW = LEN_WIDTH(DATA_WIDTH);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic [DATA_WIDTH-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic [LW-1:0]         bit_cnt_q, bit_cnt_d;
  logic                  cpol_q, cpol_d;
  logic                  cpha_q, cpha_d;
  logic                  phase_q, phase_d;
  logic                  sclk_q, sclk_d;
  logic                  mosi_q, mosi_d;
  logic                  cs_n_q, cs_n_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  tx_ready_q, tx_ready_d;
  logic                  busy_q, busy_d;
  logic                  start_c;
  logic                  tick_c;
  logic                  sample_c;

`ifdef PIRADSPI_LOOPBACK_EN
  logic                  loop_q, loop_d;
  assign sample_c = loop_q ? mosi_q : spi_miso;
`else
  assign sample_c = spi_miso;
`endif

  piradspi_clk_div #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_clk_div (
    .clk     (ACLK),
    .rst_n   (ARESETN),
    .restart (start_c),
    .en      (state_q != IDLE),
    .div     (div_q),
    .tick_c  (tick_c)
  );

  // Next-state and datapath: SETUP holds the MSB, SHIFT counts SCLK edges, HOLD closes the frame.
  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    div_d      = div_q;
    bit_cnt_d  = bit_cnt_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    phase_d    = phase_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    cs_n_d     = cs_n_q;
    rx_valid_d = 1'b0;
    start_c    = 1'b0;
`ifdef PIRADSPI_LOOPBACK_EN
    loop_d     = loop_q;
`endif

    case (state_q)
      IDLE: begin
        sclk_d = cfg_cpol;
        cs_n_d = 1'b1;
        if (tx_valid && tx_ready_q) begin
          start_c   = 1'b1;
          state_d   = SETUP;
          tx_d      = tx_data;
          cpol_d    = cfg_cpol;
          cpha_d    = cfg_cpha;
          div_d     = cfg_div;
          bit_cnt_d = cfg_len;
          phase_d   = 1'b0;
          rx_sh_d   = '0;
          cs_n_d    = 1'b0;
          mosi_d    = tx_data[cfg_len];
`ifdef PIRADSPI_LOOPBACK_EN
          loop_d    = cfg_loopback;
`endif
        end
      end

      SETUP: begin
        if (tick_c) begin
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        if (tick_c) begin
          sclk_d  = ~sclk_q;
          phase_d = ~phase_q;
          if (!phase_q) begin
            // Leading (odd) edge.
            if (cpha_q) begin
              mosi_d = tx_q[bit_cnt_q];
            end else begin
              rx_sh_d = {rx_sh_q[DATA_WIDTH-2:0], sample_c};
            end
          end else begin
            // Trailing (even) edge; the last one ends the bit loop.
            if (cpha_q) begin
              rx_sh_d = {rx_sh_q[DATA_WIDTH-2:0], sample_c};
            end else if (bit_cnt_q != '0) begin
              mosi_d = tx_q[bit_cnt_q - LW'(1)];
            end
            if (bit_cnt_q == '0) begin
              state_d = HOLD;
            end else begin
              bit_cnt_d = bit_cnt_q - LW'(1);
            end
          end
        end
      end

      HOLD: begin
        sclk_d = cpol_q;
        if (tick_c) begin
          state_d    = IDLE;
          cs_n_d     = 1'b1;
          rx_valid_d = 1'b1;
          rx_data_d  = rx_sh_q;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    tx_ready_d = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q    <= IDLE;
      tx_q       <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      div_q      <= '0;
      bit_cnt_q  <= '0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      phase_q    <= 1'b0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      rx_valid_q <= 1'b0;
      tx_ready_q <= 1'b0;
      busy_q     <= 1'b0;
`ifdef PIRADSPI_LOOPBACK_EN
      loop_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      div_q      <= div_d;
      bit_cnt_q  <= bit_cnt_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      phase_q    <= phase_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
      rx_valid_q <= rx_valid_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
`ifdef PIRADSPI_LOOPBACK_EN
      loop_q     <= loop_d;
`endif
    end
  end

  assign tx_ready = tx_ready_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = busy_q;
  assign spi_sclk = sclk_q;
  assign spi_mosi = mosi_q;
  assign spi_cs_n = cs_n_q;

endmodule
